// File: rtl/fft_frame_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// fft_frame_sched : arm / settle / stream / wait sequencer for the FFT core
// Revision        : 1.0
// ------------------------------------------------------------------
module fft_frame_sched #(
  parameter int FFT_LEN = 1024,
  parameter int DATA_W  = 12,
  parameter int SETTLE  = 50000,
  parameter int TIMEOUT = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              cont_mode,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              fft_tready,
  output logic              fft_tvalid,
  output logic [DATA_W-1:0] fft_tdata,
  output logic              fft_tlast,
  output logic              fft_abort,
  input  logic              result_done,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              busy,
  output logic              overrun,
  output logic              timeout
);

  localparam int c_IDX_W = $clog2(FFT_LEN);
  localparam int c_SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int c_TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(FFT_LEN - 1);
  localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE - 1);
  localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_STREAM = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_SET_W-1:0] r_settle_cnt;
  logic [c_TO_W-1:0]  r_to_cnt;
  logic [c_IDX_W-1:0] r_idx;

  logic               w_accept;
  logic               w_lost;
  logic [c_IDX_W-1:0] w_load_idx;

  assign w_accept   = fft_tvalid && fft_tready;
  assign w_lost     = adc_valid && fft_tvalid && !fft_tready;
  // A sample loaded in the same cycle its predecessor is accepted belongs to the next index.
  assign w_load_idx = w_accept ? (r_idx + c_IDX_W'(1)) : r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_to_cnt     <= '0;
      r_idx        <= '0;
      fft_tvalid   <= 1'b0;
      fft_tdata    <= '0;
      fft_tlast    <= 1'b0;
      fft_abort    <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      fft_abort  <= 1'b0;
      frame_done <= 1'b0;
      if (arm) begin
        r_state      <= ST_SETTLE;
        r_settle_cnt <= '0;
        r_to_cnt     <= '0;
        r_idx        <= '0;
        fft_tvalid   <= 1'b0;
        fft_tlast    <= 1'b0;
        busy         <= 1'b1;
        overrun      <= 1'b0;
        timeout      <= 1'b0;
        fft_abort    <= (r_state == ST_STREAM) || (r_state == ST_WAIT);
      end else begin
        case (r_state)
          ST_IDLE: begin
          end
          ST_SETTLE: begin
            if (r_settle_cnt == c_SET_LAST) begin
              r_settle_cnt <= '0;
              r_idx        <= '0;
              r_state      <= ST_STREAM;
            end else begin
              r_settle_cnt <= r_settle_cnt + c_SET_W'(1);
            end
          end
          ST_STREAM: begin
            if (w_lost) begin
              overrun      <= 1'b1;
              fft_abort    <= 1'b1;
              fft_tvalid   <= 1'b0;
              fft_tlast    <= 1'b0;
              r_idx        <= '0;
              r_settle_cnt <= '0;
              r_state      <= ST_SETTLE;
            end else if (w_accept && fft_tlast) begin
              fft_tvalid <= 1'b0;
              fft_tlast  <= 1'b0;
              r_idx      <= '0;
              r_to_cnt   <= '0;
              r_state    <= ST_WAIT;
            end else begin
              if (w_accept) begin
                r_idx <= r_idx + c_IDX_W'(1);
              end
              if (adc_valid) begin
                fft_tvalid <= 1'b1;
                fft_tdata  <= adc_data;
                fft_tlast  <= (w_load_idx == c_IDX_LAST);
              end else if (w_accept) begin
                fft_tvalid <= 1'b0;
                fft_tlast  <= 1'b0;
              end
            end
          end
          ST_WAIT: begin
            if (result_done) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 8'd1;
              r_idx      <= '0;
              r_to_cnt   <= '0;
              if (cont_mode) begin
                r_state <= ST_STREAM;
              end else begin
                r_state <= ST_IDLE;
                busy    <= 1'b0;
              end
            end else if (r_to_cnt == c_TO_LAST) begin
              timeout   <= 1'b1;
              fft_abort <= 1'b1;
              r_to_cnt  <= '0;
              busy      <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + c_TO_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
